// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: fetch FSM state encoding and instruction size.
package rv32i_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DISCARD = 3'd3,
    FAULT   = 3'd4
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between fetch and decode; head is read from registered storage.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push-while-full is legal alongside a pop.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues one memory request at a time,
// buffers returned words toward decode and applies branch/jump redirects.
module fetch_sequencer
  import rv32i_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_im_req,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_gnt,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_instr,
  input  logic            i_if_ready,
  output logic            o_fetch_fault,
  output fetch_state_e    o_dbg_state
);

  // Handshakes: memory request transfers on o_im_req & i_im_gnt (req may drop or change
  // address while ungranted); i_im_rvalid answers the single outstanding request;
  // decode consumes the head on o_if_valid & i_if_ready.

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_pc;
  logic             outstanding;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;

  logic [CW:0]      in_use;
  logic             has_credit;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             stale_pending;

  // Slots already spoken for: buffered words plus the one still in flight.
  assign in_use     = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
  assign has_credit = !fifo_full && (in_use < (CW+1)'(FIFO_DEPTH));

  assign o_im_req      = (state == REQ) && has_credit;
  assign o_im_addr     = pc;
  assign o_fetch_fault = (state == FAULT);
  assign o_dbg_state   = state;

  assign handshake = o_im_req && i_im_gnt;
  assign push      = (state == WAIT) && i_im_rvalid && !i_redirect_valid;
  assign pop       = o_if_valid && i_if_ready;

  // A response is still owed after this cycle unless it arrives now; a fresh grant also owes one.
  assign stale_pending = (outstanding && !i_im_rvalid) || handshake;

  assign o_if_valid = !fifo_empty;
  assign o_if_pc    = fifo_rdata[2*XLEN-1:XLEN];
  assign o_if_instr = fifo_rdata[XLEN-1:0];

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (i_redirect_valid),
    .push  (push),
    .wdata ({req_pc, i_im_rdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      outstanding <= stale_pending;
      if (i_redirect_valid) begin
        pc <= i_redirect_pc;
        if (i_redirect_pc[1:0] != 2'b00) state <= FAULT;
        else if (stale_pending)          state <= DISCARD;
        else                             state <= REQ;
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (handshake) begin
              req_pc <= pc;
              pc     <= pc + XLEN'(INSTR_BYTES);
              state  <= WAIT;
            end
          end
          WAIT:    if (i_im_rvalid) state <= REQ;
          DISCARD: if (i_im_rvalid) state <= REQ;
          FAULT:   state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder, decode consumer and an expected-PC scoreboard.
module tb_fetch_sequencer;
  import rv32i_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_redirect_valid;
  logic [31:0]  i_redirect_pc;
  logic         o_im_req;
  logic [31:0]  o_im_addr;
  logic         i_im_gnt;
  logic         i_im_rvalid;
  logic [31:0]  i_im_rdata;
  logic         o_if_valid;
  logic [31:0]  o_if_pc;
  logic [31:0]  o_if_instr;
  logic         i_if_ready;
  logic         o_fetch_fault;
  fetch_state_e o_dbg_state;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_im_req         (o_im_req),
    .o_im_addr        (o_im_addr),
    .i_im_gnt         (i_im_gnt),
    .i_im_rvalid      (i_im_rvalid),
    .i_im_rdata       (i_im_rdata),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_instr       (o_if_instr),
    .i_if_ready       (i_if_ready),
    .o_fetch_fault    (o_fetch_fault),
    .o_dbg_state      (o_dbg_state)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_addr;

  bit          pend_v   = 1'b0;
  int          pend_lat = 0;
  logic [31:0] pend_a   = '0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          gnt_rand   = 1'b0;
  bit          ready_rand = 1'b0;
  logic        ready_fixed = 1'b1;
  int          n_hs   = 0;
  int          n_pops = 0;
  logic [31:0] last_hs_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Decode must see consecutive words starting at the given address.
  task automatic load_seq(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
    exp_req_addr = start;
  endtask

  // Drive inputs for the coming posedge, check what transfers on it, then advance to the next negedge.
  task automatic step();
    logic [31:0] e;
    i_im_rvalid = 1'b0;
    if (pend_v) begin
      if (pend_lat <= 1) begin
        i_im_rvalid = 1'b1;
        i_im_rdata  = mem_word(pend_a);
        pend_v      = 1'b0;
      end else begin
        pend_lat--;
      end
    end
    i_im_gnt   = rst ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    i_if_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;

    n_checks++;
    if (o_im_req && (pend_v || i_im_rvalid)) begin
      n_fail++;
      $display("FAIL req_outstanding: req=%0b while a response is owed, required 0", o_im_req);
    end

    if (o_im_req && i_im_gnt) begin
      n_hs++;
      last_hs_addr = o_im_addr;
      if (!i_redirect_valid) begin
        n_checks++;
        if (o_im_addr !== exp_req_addr) begin
          n_fail++;
          $display("FAIL req_addr: got %h expected %h", o_im_addr, exp_req_addr);
        end
        exp_req_addr = exp_req_addr + 32'd4;
      end
      pend_v   = 1'b1;
      pend_a   = o_im_addr;
      pend_lat = $urandom_range(lat_min, lat_max);
    end

    if (o_if_valid && i_if_ready && !i_redirect_valid && !rst) begin
      n_pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got pc %h, required no delivery", o_if_pc);
      end else begin
        e = exp_q.pop_front();
        if (o_if_pc !== e || o_if_instr !== mem_word(e)) begin
          n_fail++;
          $display("FAIL decode_word: got pc %h instr %h expected pc %h instr %h",
                   o_if_pc, o_if_instr, e, mem_word(e));
        end
      end
    end

    if (rst) load_seq(RESET_PC);
    else if (i_redirect_valid) begin
      if (i_redirect_pc[1:0] == 2'b00) load_seq(i_redirect_pc);
      else begin
        exp_q.delete();
        exp_req_addr = 32'hFFFF_FFFF;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    gnt_rand = 1'b0;
    ready_rand = 1'b0;
    ready_fixed = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (4) step();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = target;
    step();
    i_redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (o_im_req !== 1'b0 || o_if_valid !== 1'b0 || o_fetch_fault !== 1'b0 ||
        o_im_addr !== RESET_PC || o_dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s: got req=%0b valid=%0b fault=%0b addr=%h state=%0d expected 0/0/0/%h/%0d",
               tag, o_im_req, o_if_valid, o_fetch_fault, o_im_addr, o_dbg_state, RESET_PC, IDLE);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_values");
    step();
    n_checks++;
    if (o_im_req !== 1'b1 || o_im_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: got req=%0b addr=%h expected 1 addr %h", o_im_req, o_im_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int p0;
    do_reset();
    p0 = n_pops;
    repeat (40) step();
    n_checks++;
    if (n_pops - p0 < 15) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words expected at least 15", n_pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int h0;
    do_reset();
    ready_fixed = 1'b0;
    h0 = n_hs;
    repeat (20) step();
    n_checks++;
    if (n_hs - h0 != DEPTH || o_if_valid !== 1'b1 || o_im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d requests valid=%0b req=%0b expected %0d/1/0",
               n_hs - h0, o_if_valid, o_im_req, DEPTH);
    end
    ready_fixed = 1'b1;
    step();
    ready_fixed = 1'b0;
    h0 = n_hs;
    repeat (6) step();
    n_checks++;
    if (n_hs - h0 != 1 || o_im_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_one_credit: got %0d requests req=%0b expected 1/0", n_hs - h0, o_im_req);
    end
    ready_fixed = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_redirect_wait();
    int h;
    int p0;
    bit found = 1'b0;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      h = n_hs;
      step();
      if (n_hs > h && last_hs_addr == 32'h8) found = 1'b1;
    end
    n_checks++;
    if (!found || o_dbg_state !== WAIT) begin
      n_fail++;
      $display("FAIL rw_setup: found=%0b state=%0d expected 1/%0d", found, o_dbg_state, WAIT);
    end
    redirect(32'h100);
    n_checks++;
    if (o_dbg_state !== DISCARD || o_if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_discard: got state=%0d valid=%0b expected %0d/0", o_dbg_state, o_if_valid, DISCARD);
    end
    p0 = n_pops;
    repeat (24) step();
    n_checks++;
    if (n_pops - p0 < 3) begin
      n_fail++;
      $display("FAIL rw_resume: got %0d words expected at least 3", n_pops - p0);
    end
  endtask

  task automatic test_redirect_gnt_rvalid();
    int p0;
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_im_req && o_im_addr == 32'h8) found = 1'b1;
      else step();
    end
    redirect(32'h300);
    n_checks++;
    if (!found || o_dbg_state !== DISCARD) begin
      n_fail++;
      $display("FAIL gnt_redirect: found=%0b state=%0d expected 1/%0d", found, o_dbg_state, DISCARD);
    end
    p0 = n_pops;
    repeat (12) step();
    n_checks++;
    if (n_pops - p0 < 3) begin
      n_fail++;
      $display("FAIL gnt_resume: got %0d words expected at least 3", n_pops - p0);
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend_v && pend_lat <= 1) found = 1'b1;
      else step();
    end
    redirect(32'h400);
    n_checks++;
    if (!found || o_dbg_state !== REQ || o_if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_redirect: found=%0b state=%0d valid=%0b expected 1/%0d/0",
               found, o_dbg_state, o_if_valid, REQ);
    end
    p0 = n_pops;
    repeat (12) step();
    n_checks++;
    if (n_pops - p0 < 3) begin
      n_fail++;
      $display("FAIL rvalid_resume: got %0d words expected at least 3", n_pops - p0);
    end
  endtask

  task automatic test_fault();
    int h0;
    int p0;
    do_reset();
    repeat (6) step();
    redirect(32'h102);
    n_checks++;
    if (o_fetch_fault !== 1'b1 || o_dbg_state !== FAULT) begin
      n_fail++;
      $display("FAIL fault_enter: got fault=%0b state=%0d expected 1/%0d", o_fetch_fault, o_dbg_state, FAULT);
    end
    h0 = n_hs;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (o_im_req !== 1'b0 || o_fetch_fault !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_hold: got req=%0b fault=%0b expected 0/1", o_im_req, o_fetch_fault);
      end
    end
    n_checks++;
    if (n_hs != h0) begin
      n_fail++;
      $display("FAIL fault_no_req: got %0d requests expected 0", n_hs - h0);
    end
    redirect(32'h200);
    n_checks++;
    if (o_fetch_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: got fault=%0b expected 0", o_fetch_fault);
    end
    p0 = n_pops;
    repeat (12) step();
    n_checks++;
    if (n_pops - p0 < 3) begin
      n_fail++;
      $display("FAIL fault_resume: got %0d words expected at least 3", n_pops - p0);
    end
  endtask

  task automatic test_wrap_and_reset();
    int h;
    int p0;
    bit saw_wrap = 1'b0;
    bit found = 1'b0;
    do_reset();
    redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 20; i++) begin
      h = n_hs;
      step();
      if (n_hs > h && last_hs_addr == 32'h0) saw_wrap = 1'b1;
    end
    n_checks++;
    if (!saw_wrap) begin
      n_fail++;
      $display("FAIL pc_wrap: got no request at 00000000 expected one after fffffffc");
    end

    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 10 && !found; i++) begin
      h = n_hs;
      step();
      if (n_hs > h) found = 1'b1;
    end
    n_checks++;
    if (!found || o_dbg_state !== WAIT) begin
      n_fail++;
      $display("FAIL mid_wait_setup: found=%0b state=%0d expected 1/%0d", found, o_dbg_state, WAIT);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mid_wait_reset");
    step();
    n_checks++;
    if (o_dbg_state !== REQ || o_if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rvalid: got state=%0d valid=%0b expected %0d/0", o_dbg_state, o_if_valid, REQ);
    end
    p0 = n_pops;
    repeat (12) step();
    n_checks++;
    if (n_pops - p0 < 3) begin
      n_fail++;
      $display("FAIL reset_resume: got %0d words expected at least 3", n_pops - p0);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    gnt_rand   = 1'b1;
    ready_rand = 1'b1;
    lat_min    = 1;
    lat_max    = 3;
    p0 = n_pops;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) redirect($urandom & 32'hFFFF_FFFC);
      else step();
    end
    gnt_rand    = 1'b0;
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    repeat (20) step();
    n_checks++;
    if (n_pops - p0 < 50) begin
      n_fail++;
      $display("FAIL random_progress: got %0d words expected at least 50", n_pops - p0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_im_gnt = 1'b0;
    i_im_rvalid = 1'b0;
    i_im_rdata = '0;
    i_if_ready = 1'b0;
    exp_req_addr = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt_rvalid();
    test_fault();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
